// File: rtl/fetch_queue.sv
// Instruction fetch queue: one-outstanding-request fetch FSM feeding a
// DEPTH-entry FIFO of {pc, instr} pairs, with redirect flush and stale-ack drop.
module fetch_queue #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  output logic                    imem_req_o,
  output logic [ADDR_W-1:0]       imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [DATA_W-1:0]       imem_data_i,
  input  logic                    stall_f_i,
  input  logic                    redirect_i,
  input  logic [ADDR_W-1:0]       redirect_pc_i,
  output logic                    valid_f_o,
  output logic [DATA_W-1:0]       instr_f_o,
  output logic [ADDR_W-1:0]       pc_f_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic          ack_live;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW-1:0] count_next;

  always_comb begin
    ack_live   = imem_ack_i && (state != IDLE);
    push       = imem_ack_i && (state == WAIT) && !redirect_i;
    pop        = valid_f_o && !stall_f_i && !redirect_i;
    count_next = count_o + CW'(push) - CW'(pop);
    // An ack in DROP retires the stale request, so it may reissue like IDLE.
    issue      = !redirect_i && (count_next < FULL) && ((state == IDLE) || ack_live);
  end

  always_comb begin
    valid_f_o = (count_o != '0);
    instr_f_o = '0;
    pc_f_o    = '0;
    if (valid_f_o) begin
      instr_f_o = instr_mem[rd_ptr];
      pc_f_o    = pc_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= imem_addr_o;
      instr_mem[wr_ptr] <= imem_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
      fetch_pc    <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
    end else if (redirect_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_o  <= '0;
      fetch_pc <= redirect_pc_i;
      // A request still in flight must be drained in DROP before reissuing.
      if (state != IDLE && !imem_ack_i) begin
        state      <= DROP;
        imem_req_o <= 1'b1;
      end else begin
        state      <= IDLE;
        imem_req_o <= 1'b0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count_o <= count_next;
      if (issue) begin
        state       <= WAIT;
        imem_req_o  <= 1'b1;
        imem_addr_o <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end else if (ack_live) begin
        state      <= IDLE;
        imem_req_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected {pc, instr} into a
// scoreboard; a negedge monitor checks every head pop against it.
module tb_fetch_queue;

  logic        clk;
  logic        reset_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        stall_f_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_f_o;
  logic [31:0] instr_f_o;
  logic [31:0] pc_f_o;
  logic [2:0]  count_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fetch_queue #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .DEPTH   (4),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .stall_f_i    (stall_f_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .valid_f_o    (valid_f_o),
    .instr_f_o    (instr_f_o),
    .pc_f_o       (pc_f_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dword(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One ack cycle for the request expected at address a.
  task automatic beat(input logic [31:0] a, input logic [31:0] d, input bit exp_push);
    chk("req_before_ack", 64'(imem_req_o), 64'd1);
    chk("req_addr", 64'(imem_addr_o), 64'(a));
    imem_ack_i  = 1'b1;
    imem_data_i = d;
    if (exp_push) sb.push_back('{a, d});
    step();
    imem_ack_i  = 1'b0;
    imem_data_i = '0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (valid_f_o && !stall_f_i && !redirect_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop_pc", 64'(pc_f_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pop_pc", 64'(pc_f_o), 64'(e.pc));
          chk("pop_instr", 64'(instr_f_o), 64'(e.instr));
        end
      end else if (!valid_f_o) begin
        chk("idle_pc_zero", 64'(pc_f_o), 64'd0);
        chk("idle_instr_zero", 64'(instr_f_o), 64'd0);
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    imem_ack_i    = 1'b0;
    imem_data_i   = '0;
    stall_f_i     = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    #3;
    chk("rst_req", 64'(imem_req_o), 64'd0);
    chk("rst_addr", 64'(imem_addr_o), 64'd0);
    chk("rst_valid", 64'(valid_f_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_pc", 64'(pc_f_o), 64'd0);
    chk("rst_instr", 64'(instr_f_o), 64'd0);
    step();
    reset_n   = 1'b1;
    stall_f_i = 1'b1;
    step();
    chk("first_req", 64'(imem_req_o), 64'd1);
    chk("first_addr", 64'(imem_addr_o), 64'd0);
    chk("first_count", 64'(count_o), 64'd0);

    // Stalled fill until full; fetch stops at DEPTH entries.
    for (int i = 0; i < 4; i++) begin
      beat(32'(4 * i), dword(32'(4 * i)), 1'b1);
      chk("fill_count", 64'(count_o), 64'(i + 1));
      chk("fill_valid", 64'(valid_f_o), 64'd1);
      chk("fill_head_pc", 64'(pc_f_o), 64'd0);
    end
    chk("full_req_off", 64'(imem_req_o), 64'd0);
    step();
    step();
    chk("full_hold_count", 64'(count_o), 64'd4);
    chk("full_hold_req", 64'(imem_req_o), 64'd0);
    chk("full_hold_pc", 64'(pc_f_o), 64'd0);
    chk("full_hold_instr", 64'(instr_f_o), 64'(dword(32'h0)));

    // Release stall: pop and resume at 0x10.
    stall_f_i = 1'b0;
    step();
    chk("resume_req", 64'(imem_req_o), 64'd1);
    chk("resume_addr", 64'(imem_addr_o), 64'h10);
    chk("resume_count", 64'(count_o), 64'd3);

    // Back-to-back ack with pop: occupancy unchanged.
    for (int i = 0; i < 4; i++) begin
      beat(32'(32'h10 + 4 * i), dword(32'(32'h10 + 4 * i)), 1'b1);
      chk("pushpop_count", 64'(count_o), 64'd3);
    end
    for (int k = 2; k >= 0; k--) begin
      step();
      chk("drain_count", 64'(count_o), 64'(k));
    end

    // Redirect while waiting on 0x24 with one entry queued.
    stall_f_i = 1'b1;
    beat(32'h20, dword(32'h20), 1'b1);
    chk("pre_redir_count", 64'(count_o), 64'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    sb.delete();
    step();
    redirect_i = 1'b0;
    stall_f_i  = 1'b0;
    chk("redir_count", 64'(count_o), 64'd0);
    chk("redir_valid", 64'(valid_f_o), 64'd0);
    chk("drop_req", 64'(imem_req_o), 64'd1);
    chk("drop_addr", 64'(imem_addr_o), 64'h24);
    step();
    step();
    chk("drop_hold_addr", 64'(imem_addr_o), 64'h24);
    chk("drop_hold_valid", 64'(valid_f_o), 64'd0);
    beat(32'h24, 32'hDEAD_BEEF, 1'b0);
    chk("drop_ack_valid", 64'(valid_f_o), 64'd0);
    chk("drop_ack_count", 64'(count_o), 64'd0);
    chk("target_req", 64'(imem_req_o), 64'd1);
    chk("target_addr", 64'(imem_addr_o), 64'h100);
    step();
    chk("target_wait_valid", 64'(valid_f_o), 64'd0);
    beat(32'h100, dword(32'h100), 1'b1);
    chk("target_valid", 64'(valid_f_o), 64'd1);
    step();
    chk("target_drained", 64'(count_o), 64'd0);

    // Redirect and ack in the same cycle: ack data discarded.
    chk("same_cyc_addr", 64'(imem_addr_o), 64'h104);
    imem_ack_i    = 1'b1;
    imem_data_i   = 32'h5555_AAAA;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    step();
    imem_ack_i  = 1'b0;
    imem_data_i = '0;
    redirect_i  = 1'b0;
    chk("same_cyc_count", 64'(count_o), 64'd0);
    chk("same_cyc_valid", 64'(valid_f_o), 64'd0);
    chk("same_cyc_req", 64'(imem_req_o), 64'd0);
    step();
    chk("same_cyc_next_req", 64'(imem_req_o), 64'd1);
    chk("same_cyc_next_addr", 64'(imem_addr_o), 64'h200);
    beat(32'h200, dword(32'h200), 1'b1);
    chk("post_redir_valid", 64'(valid_f_o), 64'd1);

    // Asynchronous reset with a request outstanding and an entry queued.
    stall_f_i = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("async_req", 64'(imem_req_o), 64'd0);
    chk("async_addr", 64'(imem_addr_o), 64'd0);
    chk("async_valid", 64'(valid_f_o), 64'd0);
    chk("async_count", 64'(count_o), 64'd0);
    chk("async_pc", 64'(pc_f_o), 64'd0);
    chk("async_instr", 64'(instr_f_o), 64'd0);
    sb.delete();
    step();
    reset_n     = 1'b1;
    stall_f_i   = 1'b0;
    imem_ack_i  = 1'b1;
    imem_data_i = 32'hBAD0_BAD0;
    step();
    imem_ack_i  = 1'b0;
    imem_data_i = '0;
    chk("stray_ack_count", 64'(count_o), 64'd0);
    chk("stray_ack_valid", 64'(valid_f_o), 64'd0);
    chk("restart_req", 64'(imem_req_o), 64'd1);
    chk("restart_addr", 64'(imem_addr_o), 64'd0);
    beat(32'h0, dword(32'h0), 1'b1);
    chk("restart_valid", 64'(valid_f_o), 64'd1);
    step();
    chk("final_count", 64'(count_o), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width.
REQ-002 Parameter ADDR_W, default 32, fetch address width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk_i  in  1  single clock; all state changes on rising edge.
REQ-006 reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 imem_req_o  out  1  fetch request pending; registered.
REQ-008 imem_addr_o  out  ADDR_W  address of pending request; registered.
REQ-009 imem_ack_i  in  1  one-cycle completion strobe; qualifies imem_data_i.
REQ-010 imem_data_i  in  DATA_W  returned instruction word.
REQ-011 stall_f_i  in  1  pipeline not accepting head entry this cycle.
REQ-012 redirect_i  in  1  branch/jump redirect; flushes queue.
REQ-013 redirect_pc_i  in  ADDR_W  new fetch address, sampled when redirect_i=1.
REQ-014 valid_f_o  out  1  head entry valid.
REQ-015 instr_f_o  out  DATA_W  head instruction; all-zero (NOP) when valid_f_o=0.
REQ-016 pc_f_o  out  ADDR_W  address of head instruction; zero when valid_f_o=0.
REQ-017 count_o  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-018 Queue SHALL be a DEPTH-entry FIFO of {pc, instr} pairs with wrapping read/write pointers.
REQ-019 Pop SHALL occur when valid_f_o=1 and stall_f_i=0 and redirect_i=0.
REQ-020 Push SHALL occur only on imem_ack_i=1 in state WAIT with redirect_i=0; entry = {imem_addr_o, imem_data_i}.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH.
REQ-022 At most one request SHALL be outstanding; FSM states IDLE, WAIT, DROP.
REQ-023 imem_req_o SHALL be 1 exactly when state is WAIT or DROP; imem_addr_o SHALL stay constant while imem_req_o=1.
REQ-024 count_next := count + push - pop; a request issues (next state WAIT, imem_addr_o <= fetch pc, fetch pc += 4 mod 2^ADDR_W) when redirect_i=0 and count_next < DEPTH and (state IDLE, or state WAIT with imem_ack_i=1).
REQ-025 WAIT with imem_ack_i=1 and no issue SHALL go to IDLE; WAIT without ack SHALL stay WAIT.
REQ-026 redirect_i=1 SHALL empty the FIFO, load fetch pc with redirect_pc_i, and issue no request that cycle.
REQ-027 redirect_i=1 in WAIT without ack SHALL go to DROP; in WAIT with ack, in IDLE, or in DROP with ack SHALL go to IDLE; in DROP without ack SHALL stay DROP.
REQ-028 In DROP, the ack SHALL complete the old transaction and its data SHALL be discarded; without redirect, DROP+ack follows REQ-024 from IDLE (may issue at redirect target).
REQ-029 Ack data arriving in the same cycle as redirect_i SHALL be discarded.
REQ-030 imem_ack_i in IDLE SHALL be ignored.
REQ-031 Stall SHALL hold head outputs stable; fetching continues until count=DEPTH.
REQ-032 Latency: ack at cycle N SHALL produce valid_f_o=1 at cycle N+1 when queue was empty.
REQ-033 Queue SHALL never overflow or underflow; count_o <= DEPTH always.

Reset
REQ-034 reset_n_i=0 SHALL immediately force: state IDLE, FIFO empty, count_o=0, valid_f_o=0, instr_f_o=0, pc_f_o=0, imem_req_o=0, imem_addr_o=0, fetch pc=RESET_PC.
REQ-035 Reset mid-transaction SHALL abandon the outstanding request; a later stray ack SHALL be ignored (REQ-030).
REQ-036 First request SHALL issue on the first clock edge after reset release, to RESET_PC.

Verification
REQ-037 Reset release, ack 1 cycle after every req, stall_f_i=0 -> addresses 0x0,0x4,0x8,... in order; pc_f_o/instr_f_o match returned words.
REQ-038 stall_f_i=1 held, DEPTH=4 -> exactly 4 pushes, count_o=4, imem_req_o=0; release stall -> pops in order, fetch resumes at 0x10.
REQ-039 redirect_i=1, redirect_pc_i=0x100 while WAIT on 0x8, ack 3 cycles later with 0xDEADBEEF -> data dropped, next request 0x100, valid_f_o=0 until its ack.
REQ-040 redirect and ack in same cycle -> ack data discarded, count_o=0 next cycle, next imem_addr_o=redirect_pc_i.
REQ-041 count=DEPTH, pop and ack-push same cycle -> count_o stays DEPTH, order preserved.
REQ-042 reset_n_i pulsed low while imem_req_o=1 -> outputs reset asynchronously; ack after release ignored; fetch restarts at RESET_PC.
